// File: rtl/servant_irq_ctrl.sv
// Interrupt/timer controller for the servant SoC: prescaled 32-bit mtime with
// mtimecmp compare, plus NSRC edge-triggered external sources with claim.
module servant_irq_ctrl #(
  parameter int unsigned NSRC       = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [2:0]      i_wb_adr,
  input  logic [31:0]     i_wb_dat,
  input  logic            i_wb_we,
  input  logic            i_wb_cyc,
  output logic [31:0]     o_wb_rdt,
  output logic            o_wb_ack,
  input  logic [NSRC-1:0] i_irq,
  output logic            o_timer_irq,
  output logic            o_ext_irq
);

  typedef enum logic [2:0] {
    ADR_MTIME    = 3'd0,
    ADR_MTIMECMP = 3'd1,
    ADR_PENDING  = 3'd2,
    ADR_ENABLE   = 3'd3,
    ADR_CLAIM    = 3'd4,
    ADR_CTRL     = 3'd5
  } reg_adr_e;

  logic [31:0]           mtime_q,    mtime_d;
  logic [31:0]           mtimecmp_q, mtimecmp_d;
  logic [NSRC-1:0]       pending_q,  pending_d;
  logic [NSRC-1:0]       enable_q,   enable_d;
  logic [NSRC-1:0]       irq_q;
  logic [PRESCALE_W-1:0] div_q,      div_d;
  logic [PRESCALE_W-1:0] presc_q,    presc_d;
  logic                  ten_q,      ten_d;
  logic                  ack_q;
  logic [31:0]           rdt_q,      rdt_d;

  logic            access, wr, rd, tick;
  logic            claim_valid, claim_take;
  logic [4:0]      claim_id;
  logic [NSRC-1:0] claim_onehot, clr_mask, src_edge, masked;
  reg_adr_e        adr;

  assign adr      = reg_adr_e'(i_wb_adr);
  assign access   = i_wb_cyc & ~ack_q;
  assign wr       = access & i_wb_we;
  assign rd       = access & ~i_wb_we;
  assign tick     = ten_q & (presc_q == div_q);
  assign src_edge = i_irq & ~irq_q;
  assign masked   = pending_q & enable_q;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    claim_valid  = 1'b0;
    claim_id     = 5'd0;
    claim_onehot = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        claim_valid  = 1'b1;
        claim_id     = 5'(i);
        claim_onehot = NSRC'(1) << i;
      end
    end
  end

  assign claim_take = rd & (adr == ADR_CLAIM) & claim_valid;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    enable_d   = enable_q;
    div_d      = div_q;
    ten_d      = ten_q;
    presc_d    = presc_q;
    rdt_d      = 32'd0;
    clr_mask   = '0;

    if (!ten_q || tick) presc_d = '0;
    else                presc_d = presc_q + 1'b1;
    if (tick) mtime_d = mtime_q + 32'd1;

    if (wr) begin
      unique case (adr)
        ADR_MTIME:    mtime_d    = i_wb_dat;
        ADR_MTIMECMP: mtimecmp_d = i_wb_dat;
        ADR_PENDING:  clr_mask   = i_wb_dat[NSRC-1:0];
        ADR_ENABLE:   enable_d   = i_wb_dat[NSRC-1:0];
        ADR_CTRL: begin
          div_d   = i_wb_dat[PRESCALE_W+7:8];
          ten_d   = i_wb_dat[0];
          presc_d = '0;
        end
        default: ;
      endcase
    end

    if (rd) begin
      unique case (adr)
        ADR_MTIME:    rdt_d = mtime_q;
        ADR_MTIMECMP: rdt_d = mtimecmp_q;
        ADR_PENDING:  rdt_d = 32'(pending_q);
        ADR_ENABLE:   rdt_d = 32'(enable_q);
        ADR_CLAIM:    rdt_d = claim_valid ? {1'b1, 26'd0, claim_id} : 32'd0;
        ADR_CTRL:     rdt_d = (32'(div_q) << 8) | 32'(ten_q);
        default:      rdt_d = 32'd0;
      endcase
    end

    if (claim_take) clr_mask = clr_mask | claim_onehot;
    // A fresh edge always beats a clear in the same cycle.
    pending_d = (pending_q & ~clr_mask) | src_edge;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and covers all state.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      mtime_q    <= 32'd0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      pending_q  <= '0;
      enable_q   <= '0;
      irq_q      <= '0;
      div_q      <= '0;
      presc_q    <= '0;
      ten_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdt_q      <= 32'd0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      irq_q      <= i_irq;
      div_q      <= div_d;
      presc_q    <= presc_d;
      ten_q      <= ten_d;
      ack_q      <= access;
      rdt_q      <= rdt_d;
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_rdt    = rdt_q;
  assign o_timer_irq = ten_q & (mtime_q >= mtimecmp_q);
  assign o_ext_irq   = |masked;

endmodule
